// File: rtl/tile_state_ctrl.sv
// Per-tile game state for the minesweeper board: click edge detection, flag/reveal bookkeeping,
// mine lookup handshake, win/lose detection and a registered read port for the board drawer.
module tile_state_ctrl #(
  parameter int unsigned MAX_DIM = 16,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bomb,
  input  logic             flag,
  input  logic [IDX_W-1:0] button_index_x,
  input  logic [IDX_W-1:0] button_index_y,
  input  logic [IDX_W-1:0] button_num,
  input  logic [CNT_W-1:0] mine_count,
  input  logic             clear,
  output logic             mine_req,
  output logic [IDX_W-1:0] mine_x,
  output logic [IDX_W-1:0] mine_y,
  input  logic             mine_ack,
  input  logic             mine_hit,
  input  logic [IDX_W-1:0] rd_x,
  input  logic [IDX_W-1:0] rd_y,
  output logic [1:0]       rd_state,
  output logic [CNT_W-1:0] flags_left,
  output logic [CNT_W-1:0] revealed_cnt,
  output logic             busy,
  output logic             game_over,
  output logic             game_won
);

  localparam int unsigned NumTiles = MAX_DIM * MAX_DIM;
  localparam int unsigned AddrW    = $clog2(NumTiles);

  localparam logic [1:0] TileCovered  = 2'b00;
  localparam logic [1:0] TileFlagged  = 2'b01;
  localparam logic [1:0] TileRevealed = 2'b10;
  localparam logic [1:0] TileMine     = 2'b11;

  typedef enum logic [1:0] {StIdle, StLookup, StClear, StEnd} state_e;

  // Also rejects indices beyond the array so an oversized button_num cannot alias tiles.
  function automatic logic in_board(input logic [IDX_W-1:0] x, input logic [IDX_W-1:0] y,
                                    input logic [IDX_W-1:0] n);
    return (x != '0) && (y != '0) && (x <= n) && (y <= n) &&
           (32'(x) <= MAX_DIM) && (32'(y) <= MAX_DIM);
  endfunction

  function automatic logic [AddrW-1:0] tile_addr(input logic [IDX_W-1:0] x,
                                                 input logic [IDX_W-1:0] y);
    return AddrW'((32'(y) - 32'd1) * MAX_DIM + (32'(x) - 32'd1));
  endfunction

  state_e           state_q, state_d;
  logic             bomb_q, flag_q;
  logic             mine_req_q, mine_req_d;
  logic [IDX_W-1:0] mine_x_q, mine_x_d;
  logic [IDX_W-1:0] mine_y_q, mine_y_d;
  logic [CNT_W-1:0] flags_left_q, flags_left_d;
  logic [CNT_W-1:0] revealed_q, revealed_d;
  logic             over_q, over_d;
  logic             won_q, won_d;
  logic [AddrW-1:0] sweep_q, sweep_d;
  logic [1:0]       rd_state_q, rd_state_d;
  logic [1:0]       tiles_q [NumTiles];

  logic             we;
  logic [AddrW-1:0] waddr;
  logic [1:0]       wdata;

  logic             bomb_ev, flag_ev, click_ok, win_now;
  logic [AddrW-1:0] click_addr, look_addr;
  logic [1:0]       click_tile;

  // A simultaneous rise of both buttons counts as a bomb click only.
  assign bomb_ev    = bomb & ~bomb_q;
  assign flag_ev    = flag & ~flag_q & ~bomb_ev;
  assign click_ok   = in_board(button_index_x, button_index_y, button_num);
  assign click_addr = tile_addr(button_index_x, button_index_y);
  assign click_tile = tiles_q[click_addr];
  assign look_addr  = tile_addr(mine_x_q, mine_y_q);
  assign win_now    = (32'(revealed_q) + 32'd1 + 32'(mine_count)) ==
                      (32'(button_num) * 32'(button_num));

  always_comb begin
    state_d      = state_q;
    mine_req_d   = mine_req_q;
    mine_x_d     = mine_x_q;
    mine_y_d     = mine_y_q;
    flags_left_d = flags_left_q;
    revealed_d   = revealed_q;
    over_d       = over_q;
    won_d        = won_q;
    sweep_d      = sweep_q;
    we           = 1'b0;
    waddr        = click_addr;
    wdata        = TileCovered;

    if (clear) begin
      state_d      = StClear;
      sweep_d      = '0;
      mine_req_d   = 1'b0;
      flags_left_d = mine_count;
      revealed_d   = '0;
      over_d       = 1'b0;
      won_d        = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (click_ok) begin
            if (bomb_ev && click_tile == TileCovered) begin
              state_d    = StLookup;
              mine_req_d = 1'b1;
              mine_x_d   = button_index_x;
              mine_y_d   = button_index_y;
            end else if (flag_ev) begin
              if (click_tile == TileCovered && flags_left_q != '0) begin
                we           = 1'b1;
                wdata        = TileFlagged;
                flags_left_d = flags_left_q - 1'b1;
              end else if (click_tile == TileFlagged) begin
                we    = 1'b1;
                wdata = TileCovered;
                if (flags_left_q != '1) flags_left_d = flags_left_q + 1'b1;
              end
            end
          end
        end
        StLookup: begin
          if (mine_ack) begin
            mine_req_d = 1'b0;
            we         = 1'b1;
            waddr      = look_addr;
            if (mine_hit) begin
              wdata   = TileMine;
              over_d  = 1'b1;
              state_d = StEnd;
            end else begin
              wdata = TileRevealed;
              if (revealed_q != '1) revealed_d = revealed_q + 1'b1;
              if (win_now) begin
                won_d   = 1'b1;
                state_d = StEnd;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        StClear: begin
          we      = 1'b1;
          waddr   = sweep_q;
          wdata   = TileCovered;
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == AddrW'(NumTiles - 1)) state_d = StIdle;
        end
        StEnd: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // The sweep hides stale tiles from the drawer until every entry has been rewritten.
  always_comb begin
    rd_state_d = TileCovered;
    if (state_q != StClear && in_board(rd_x, rd_y, button_num)) begin
      rd_state_d = tiles_q[tile_addr(rd_x, rd_y)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bomb_q       <= 1'b0;
      flag_q       <= 1'b0;
      mine_req_q   <= 1'b0;
      mine_x_q     <= '0;
      mine_y_q     <= '0;
      flags_left_q <= '0;
      revealed_q   <= '0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
      sweep_q      <= '0;
      rd_state_q   <= TileCovered;
    end else begin
      state_q      <= state_d;
      bomb_q       <= bomb;
      flag_q       <= flag;
      mine_req_q   <= mine_req_d;
      mine_x_q     <= mine_x_d;
      mine_y_q     <= mine_y_d;
      flags_left_q <= flags_left_d;
      revealed_q   <= revealed_d;
      over_q       <= over_d;
      won_q        <= won_d;
      sweep_q      <= sweep_d;
      rd_state_q   <= rd_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumTiles); i++) tiles_q[i] <= TileCovered;
    end else if (we) begin
      tiles_q[waddr] <= wdata;
    end
  end

  assign mine_req     = mine_req_q;
  assign mine_x       = mine_x_q;
  assign mine_y       = mine_y_q;
  assign rd_state     = rd_state_q;
  assign flags_left   = flags_left_q;
  assign revealed_cnt = revealed_q;
  assign busy         = (state_q == StClear);
  assign game_over    = over_q;
  assign game_won     = won_q;

endmodule
